// File: rtl/signal_generator_sequencer.sv
// Steps one waveform-generator channel through a table of configurations, switching only on DDS phase wraps.
// Optional macro SIGGEN_SEQ_EXT_TRIG_EN adds an ext_trig input that gates the start of the sequence.
module signal_generator_sequencer #(
    parameter int CFG_DATA_WIDTH = 64,
    parameter int PHASE_WIDTH    = 16,
    parameter int NUM_STEPS      = 4,
    parameter int REPEAT_WIDTH   = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
`ifdef SIGGEN_SEQ_EXT_TRIG_EN
    input  logic                                  ext_trig,
`endif
    input  logic                                  enable,
    input  logic                                  loop,
    input  logic [$clog2(NUM_STEPS)-1:0]          last_step,
    input  logic [NUM_STEPS*CFG_DATA_WIDTH-1:0]   step_cfg,
    input  logic [NUM_STEPS*REPEAT_WIDTH-1:0]     step_repeat,
    input  logic [PHASE_WIDTH-1:0]                s_axis_tdata_phase,
    input  logic                                  s_axis_tvalid_phase,
    output logic [CFG_DATA_WIDTH-1:0]             gen_cfg_data,
    output logic                                  gen_aresetn,
    output logic [$clog2(NUM_STEPS)-1:0]          step_index,
    output logic                                  busy,
    output logic                                  done
);

    localparam int IDX_W = $clog2(NUM_STEPS);
    localparam logic [IDX_W-1:0]        IDX_ONE = 1;
    localparam logic [REPEAT_WIDTH-1:0] REP_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                    r_state;
    logic                      r_prev_msb;
    logic [REPEAT_WIDTH-1:0]   r_count;
    logic [REPEAT_WIDTH-1:0]   r_target;
    logic [IDX_W-1:0]          r_step_index;
    logic [CFG_DATA_WIDTH-1:0] r_cfg;
    logic                      r_aresetn;
    logic                      r_busy;
    logic                      r_done;

    logic [CFG_DATA_WIDTH-1:0] w_cfg_tab [NUM_STEPS];
    logic [REPEAT_WIDTH-1:0]   w_tgt_tab [NUM_STEPS];
    logic                      w_wrap;
    logic                      w_trig_ok;
    logic                      w_at_last;
    logic [IDX_W-1:0]          w_next_idx;
    logic [REPEAT_WIDTH-1:0]   w_count_inc;
    logic                      w_unused_phase;

    // Unpack the flat tables; a repeat of 0 becomes a target of one period.
    for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_tab
        assign w_cfg_tab[gi] = step_cfg[gi*CFG_DATA_WIDTH +: CFG_DATA_WIDTH];
        assign w_tgt_tab[gi] = (step_repeat[gi*REPEAT_WIDTH +: REPEAT_WIDTH] == '0)
                             ? REP_ONE : step_repeat[gi*REPEAT_WIDTH +: REPEAT_WIDTH];
    end

    assign w_unused_phase = &{1'b0, s_axis_tdata_phase[PHASE_WIDTH-2:0]};

    assign w_wrap      = s_axis_tvalid_phase & ~s_axis_tdata_phase[PHASE_WIDTH-1] & r_prev_msb;
    assign w_at_last   = (r_step_index == last_step);
    assign w_next_idx  = w_at_last ? '0 : r_step_index + IDX_ONE;
    assign w_count_inc = (r_count == '1) ? r_count : r_count + REP_ONE;

`ifdef SIGGEN_SEQ_EXT_TRIG_EN
    logic r_trig;
    assign w_trig_ok = r_trig | ext_trig;

    always_ff @(posedge clk) begin
        if (reset || r_state != S_ARM || (w_wrap && w_trig_ok) || !enable) begin
            r_trig <= 1'b0;
        end else if (ext_trig) begin
            r_trig <= 1'b1;
        end
    end
`else
    assign w_trig_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_prev_msb   <= 1'b0;
            r_count      <= '0;
            r_target     <= REP_ONE;
            r_step_index <= '0;
            r_cfg        <= '0;
            r_aresetn    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            if (s_axis_tvalid_phase) begin
                r_prev_msb <= s_axis_tdata_phase[PHASE_WIDTH-1];
            end
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_aresetn    <= 1'b0;
                    r_cfg        <= w_cfg_tab[0];
                    r_target     <= w_tgt_tab[0];
                    r_step_index <= '0;
                    r_count      <= '0;
                    r_busy       <= enable;
                    if (enable) begin
                        r_state <= S_ARM;
                    end
                end

                S_ARM: begin
                    r_cfg    <= w_cfg_tab[0];
                    r_target <= w_tgt_tab[0];
                    r_count  <= '0;
                    if (!enable) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_aresetn <= 1'b0;
                    end else if (w_wrap && w_trig_ok) begin
                        r_state   <= S_RUN;
                        r_aresetn <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (!enable) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_aresetn    <= 1'b0;
                        r_step_index <= '0;
                    end else if (w_wrap) begin
                        if (w_count_inc >= r_target) begin
                            r_count   <= '0;
                            r_aresetn <= 1'b0;
                            if (!w_at_last || loop) begin
                                r_state      <= S_LOAD;
                                r_step_index <= w_next_idx;
                                r_cfg        <= w_cfg_tab[w_next_idx];
                                r_target     <= w_tgt_tab[w_next_idx];
                            end else begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_count <= w_count_inc;
                        end
                    end
                end

                S_LOAD: begin
                    if (!enable) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_aresetn    <= 1'b0;
                        r_step_index <= '0;
                    end else begin
                        // A wrap landing on the load cycle already belongs to the new step.
                        r_state   <= S_RUN;
                        r_aresetn <= 1'b1;
                        r_count   <= w_wrap ? REP_ONE : '0;
                    end
                end

                S_DONE: begin
                    r_aresetn <= 1'b0;
                    r_busy    <= 1'b0;
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_aresetn <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign gen_cfg_data = r_cfg;
    assign gen_aresetn  = r_aresetn;
    assign step_index   = r_step_index;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_signal_generator_sequencer.sv
// Directed bench for signal_generator_sequencer: a 64-cycle phase ramp, a table of per-wrap
// expectations for three sequences, plus hand-written reset, abort and (optional) trigger cases.
module tb_signal_generator_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         loop;
    logic [1:0]   last_step;
    logic [255:0] step_cfg;
    logic [63:0]  step_repeat;
    logic [15:0]  phase;
    logic         phase_valid;
    logic [63:0]  gen_cfg_data;
    logic         gen_aresetn;
    logic [1:0]   step_index;
    logic         busy;
    logic         done;
`ifdef SIGGEN_SEQ_EXT_TRIG_EN
    logic         ext_trig;
`endif

    always #4 clk = ~clk;

    signal_generator_sequencer #(
        .CFG_DATA_WIDTH(64),
        .PHASE_WIDTH   (16),
        .NUM_STEPS     (4),
        .REPEAT_WIDTH  (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
`ifdef SIGGEN_SEQ_EXT_TRIG_EN
        .ext_trig           (ext_trig),
`endif
        .enable             (enable),
        .loop               (loop),
        .last_step          (last_step),
        .step_cfg           (step_cfg),
        .step_repeat        (step_repeat),
        .s_axis_tdata_phase (phase),
        .s_axis_tvalid_phase(phase_valid),
        .gen_cfg_data       (gen_cfg_data),
        .gen_aresetn        (gen_aresetn),
        .step_index         (step_index),
        .busy               (busy),
        .done               (done)
    );

    typedef struct {
        int   scen;
        int   wrap;
        logic rstn;
        int   idx;
        logic bsy;
        logic dn;
        logic rstn_n;
        logic dn_n;
    } vec_t;

    logic [63:0] cfgs [4];
    vec_t        vecs [13];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          wrap_cnt;
    int          done_cnt;
    logic [15:0] ph;
    logic        prev_msb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // One clock with the ramp advancing; the bench tracks wraps from what it drives.
    task automatic tick();
        logic w;
        phase       = ph;
        phase_valid = 1'b1;
        w = ~ph[15] & prev_msb;
        @(posedge clk);
        #1;
        prev_msb = ph[15];
        ph       = ph + 16'd1024;
        if (w) wrap_cnt++;
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic do_reset(input logic lp, input logic [15:0] rep0, input logic [15:0] rep1);
        reset       = 1'b1;
        enable      = 1'b0;
        loop        = lp;
        step_repeat = {16'd0, 16'd0, rep1, rep0};
        phase       = 16'd0;
        phase_valid = 1'b0;
`ifdef SIGGEN_SEQ_EXT_TRIG_EN
        ext_trig    = 1'b0;
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        ph       = 16'd0;
        prev_msb = 1'b0;
        wrap_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic advance_to_wrap(input int target);
        int n;
        n = 0;
        while (wrap_cnt < target && n < 5000) begin
            tick();
            n++;
        end
        if (wrap_cnt < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wrap_timeout: got %0d expected %0d", wrap_cnt, target);
        end
    endtask

    task automatic end_scenario(input int scen);
        repeat (70) tick();
        chk($sformatf("s%0d_done_count", scen), 64'(done_cnt), (scen == 1) ? 64'd0 : 64'd1);
    endtask

    initial begin
        int cur;
        cfgs[0] = 64'h0000_0400_7FFF_0001;
        cfgs[1] = 64'h0000_0200_4000_0002;
        cfgs[2] = 64'h0000_0100_2000_0003;
        cfgs[3] = 64'h0000_0080_1000_0004;
        step_cfg  = {cfgs[3], cfgs[2], cfgs[1], cfgs[0]};
        last_step = 2'd1;

        //         scen wrap rstn idx busy done | rstn_n done_n
        vecs[0]  = '{0, 1,  1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{0, 2,  1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{0, 3,  1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{0, 5,  1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{0, 6,  1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1, 1,  1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1, 3,  1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1, 6,  1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1, 8,  1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1, 11, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{2, 1,  1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2, 2,  1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{2, 5,  1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset values, then one idle cycle picks up step 0.
        do_reset(1'b0, 16'd2, 16'd3);
        chk("rst_aresetn", 64'(gen_aresetn), 64'd0);
        chk("rst_busy",    64'(busy),        64'd0);
        chk("rst_done",    64'(done),        64'd0);
        chk("rst_index",   64'(step_index),  64'd0);
        chk("rst_cfg",     gen_cfg_data,     64'd0);
        tick();
        chk("idle_cfg",     gen_cfg_data,     cfgs[0]);
        chk("idle_aresetn", 64'(gen_aresetn), 64'd0);

        cur = -1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].scen != cur) begin
                if (cur >= 0) end_scenario(cur);
                cur = vecs[i].scen;
                do_reset(cur == 1, (cur == 2) ? 16'd0 : 16'd2, 16'd3);
                enable = 1'b1;
                tick();
                chk($sformatf("s%0d_arm_busy", cur), 64'(busy), 64'd1);
            end
            advance_to_wrap(vecs[i].wrap);
            chk($sformatf("s%0d_w%0d_aresetn", cur, vecs[i].wrap), 64'(gen_aresetn), 64'(vecs[i].rstn));
            chk($sformatf("s%0d_w%0d_index", cur, vecs[i].wrap), 64'(step_index), 64'(vecs[i].idx));
            chk($sformatf("s%0d_w%0d_cfg", cur, vecs[i].wrap), gen_cfg_data, cfgs[vecs[i].idx]);
            chk($sformatf("s%0d_w%0d_busy", cur, vecs[i].wrap), 64'(busy), 64'(vecs[i].bsy));
            chk($sformatf("s%0d_w%0d_done", cur, vecs[i].wrap), 64'(done), 64'(vecs[i].dn));
            tick();
            chk($sformatf("s%0d_w%0d_aresetn_next", cur, vecs[i].wrap), 64'(gen_aresetn), 64'(vecs[i].rstn_n));
            chk($sformatf("s%0d_w%0d_done_next", cur, vecs[i].wrap), 64'(done), 64'(vecs[i].dn_n));
        end
        end_scenario(cur);

        // Abort on the very wrap that would otherwise load step 1.
        do_reset(1'b0, 16'd2, 16'd3);
        enable = 1'b1;
        advance_to_wrap(1);
        while (ph != 16'd0) tick();
        enable = 1'b0;
        tick();
        chk("abort_aresetn", 64'(gen_aresetn), 64'd0);
        chk("abort_index",   64'(step_index),  64'd0);
        chk("abort_busy",    64'(busy),        64'd0);
        tick();
        chk("abort_aresetn_next", 64'(gen_aresetn), 64'd0);
        chk("abort_cfg_next",     gen_cfg_data,     cfgs[0]);

`ifdef SIGGEN_SEQ_EXT_TRIG_EN
        // Start is held until a wrap at or after the trigger.
        do_reset(1'b0, 16'd2, 16'd3);
        enable = 1'b1;
        advance_to_wrap(3);
        chk("trig_w3_aresetn", 64'(gen_aresetn), 64'd0);
        chk("trig_w3_busy",    64'(busy),        64'd1);
        repeat (10) tick();
        ext_trig = 1'b1;
        tick();
        ext_trig = 1'b0;
        advance_to_wrap(4);
        chk("trig_w4_aresetn", 64'(gen_aresetn), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
